// File: rtl/div_unit.sv
// div_unit: radix-2 restoring integer divider (DIV/DIVU), one quotient bit per clock.
// Result is {remainder, quotient}; operands are latched on the accepting edge.
`default_nettype none

module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_DONE = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [1:0] S_FREE   = 2'd0;
  localparam logic [1:0] S_BYZERO = 2'd1;
  localparam logic [1:0] S_ON     = 2'd2;
  localparam logic [1:0] S_END    = 2'd3;

  logic [1:0]           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH:0]     dreg_q, dreg_d;
  logic [WIDTH-1:0]     divisor_q, divisor_d;
  logic                 neg_quot_q, neg_quot_d;
  logic                 neg_rem_q, neg_rem_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic                 ready_q, ready_d;

  logic                 start_ok;
  logic                 op1_neg, op2_neg;
  logic [WIDTH-1:0]     op1_abs, op2_abs;
  logic [WIDTH:0]       diff;
  logic [WIDTH-1:0]     quot, rem, quot_fix, rem_fix;

  assign start_ok = start_i & ~annul_i;
  assign op1_neg  = signed_div_i & opdata1_i[WIDTH-1];
  assign op2_neg  = signed_div_i & opdata2_i[WIDTH-1];
  // The most-negative value negates to itself, which is the correct unsigned magnitude.
  assign op1_abs  = op1_neg ? -opdata1_i : opdata1_i;
  assign op2_abs  = op2_neg ? -opdata2_i : opdata2_i;

  assign diff     = dreg_q[2*WIDTH:WIDTH] - {1'b0, divisor_q};
  assign quot     = dreg_q[WIDTH-1:0];
  assign rem      = dreg_q[2*WIDTH:WIDTH+1];
  assign quot_fix = neg_quot_q ? -quot : quot;
  assign rem_fix  = neg_rem_q ? -rem : rem;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_FREE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FREE:   if (start_ok) state_d = (opdata2_i == '0) ? S_BYZERO : S_ON;
      S_ON: begin
        if (annul_i)                state_d = S_FREE;
        else if (cnt_q == CNT_DONE) state_d = S_END;
      end
      S_BYZERO: state_d = annul_i ? S_FREE : S_END;
      S_END:    if (!start_i) state_d = S_FREE;
      default:  state_d = S_FREE;
    endcase
  end

  always_comb begin
    cnt_d      = cnt_q;
    dreg_d     = dreg_q;
    divisor_d  = divisor_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    result_d   = result_q;
    ready_d    = ready_q;
    case (state_q)
      S_FREE: begin
        if (start_ok) begin
          dreg_d     = {{WIDTH{1'b0}}, op1_abs, 1'b0};
          divisor_d  = op2_abs;
          neg_quot_d = op1_neg ^ op2_neg;
          neg_rem_d  = op1_neg;
          cnt_d      = '0;
        end
      end
      S_ON: begin
        if (annul_i) begin
          cnt_d    = '0;
          result_d = '0;
          ready_d  = 1'b0;
        end else if (cnt_q != CNT_DONE) begin
          if (diff[WIDTH]) dreg_d = {dreg_q[2*WIDTH-1:0], 1'b0};
          else             dreg_d = {diff[WIDTH-1:0], dreg_q[WIDTH-1:0], 1'b1};
          cnt_d = cnt_q + CNT_ONE;
        end else begin
          result_d = {rem_fix, quot_fix};
          ready_d  = 1'b1;
        end
      end
      S_BYZERO: begin
        if (!annul_i) begin
          result_d = '0;
          ready_d  = 1'b1;
        end
      end
      S_END: begin
        if (!start_i) begin
          result_d = '0;
          ready_d  = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q      <= '0;
      dreg_q     <= '0;
      divisor_q  <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      result_q   <= '0;
      ready_q    <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      dreg_q     <= dreg_d;
      divisor_q  <= divisor_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      result_q   <= result_d;
      ready_q    <= ready_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule

`default_nettype wire

// File: tb/tb_div_unit.sv
// tb_div_unit: scoreboard bench for div_unit, one WIDTH=32 and one WIDTH=8 instance.
`default_nettype none

module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst32, rst8;
  logic        sg32, sg8, start32, start8, annul32, annul8;
  logic [31:0] op1_32, op2_32;
  logic [7:0]  op1_8, op2_8;
  logic [63:0] res32;
  logic [15:0] res8;
  logic        rdy32, rdy8;

  int checks = 0;
  int errors = 0;
  logic [63:0] sb32[$];
  logic [63:0] sb8[$];

  always #5 clk = ~clk;

  div_unit #(.WIDTH(32)) u_div32 (
    .clk(clk), .rst(rst32), .signed_div_i(sg32), .opdata1_i(op1_32), .opdata2_i(op2_32),
    .start_i(start32), .annul_i(annul32), .result_o(res32), .ready_o(rdy32)
  );

  div_unit #(.WIDTH(8)) u_div8 (
    .clk(clk), .rst(rst8), .signed_div_i(sg8), .opdata1_i(op1_8), .opdata2_i(op2_8),
    .start_i(start8), .annul_i(annul8), .result_o(res8), .ready_o(rdy8)
  );

  // Reference: wide signed arithmetic truncates toward zero, remainder follows dividend.
  function automatic logic [63:0] ref_div(input bit sgn, input int w, input logic [31:0] a, input logic [31:0] b);
    longint mask, sa, sb, q, r;
    mask = (longint'(1) << w) - 1;
    sa = longint'(a) & mask;
    sb = longint'(b) & mask;
    if (sgn && sa[w-1]) sa = sa - (longint'(1) << w);
    if (sgn && sb[w-1]) sb = sb - (longint'(1) << w);
    if (sb == 0) return 64'd0;
    q = sa / sb;
    r = sa % sb;
    return 64'(((r & mask) << w) | (q & mask));
  endfunction

  function automatic logic cur_rdy(input bit w8);
    return w8 ? rdy8 : rdy32;
  endfunction

  function automatic logic [63:0] cur_res(input bit w8);
    return w8 ? {48'd0, res8} : res32;
  endfunction

  task automatic start_div(input bit w8, input bit sgn, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    if (w8) begin
      sg8 = sgn; op1_8 = a[7:0]; op2_8 = b[7:0]; start8 = 1'b1; annul8 = 1'b0;
      sb8.push_back(ref_div(sgn, 8, a, b));
    end else begin
      sg32 = sgn; op1_32 = a; op2_32 = b; start32 = 1'b1; annul32 = 1'b0;
      sb32.push_back(ref_div(sgn, 32, a, b));
    end
    @(posedge clk);
  endtask

  task automatic wait_result(input bit w8, input int lat, input bit scramble, input string name);
    int cyc;
    logic [63:0] exp;
    cyc = 0;
    while (cyc < 100) begin
      @(posedge clk);
      cyc++;
      #1;
      if (cur_rdy(w8)) break;
      if (scramble && cyc == 5) begin
        op1_32 = ~op1_32; op2_32 = 32'd0; sg32 = ~sg32;
      end
    end
    exp = w8 ? sb8.pop_front() : sb32.pop_front();
    checks++;
    if (!cur_rdy(w8) || cyc != lat)
      begin errors++; $display("FAIL %s latency: got %0d cycles (ready=%b), required %0d", name, cyc, cur_rdy(w8), lat); end
    checks++;
    if (cur_res(w8) !== exp)
      begin errors++; $display("FAIL %s result: got %h, required %h", name, cur_res(w8), exp); end
    @(posedge clk); #1;
    checks++;
    if (cur_rdy(w8) !== 1'b1 || cur_res(w8) !== exp)
      begin errors++; $display("FAIL %s hold: got ready=%b result=%h, required ready=1 result=%h", name, cur_rdy(w8), cur_res(w8), exp); end
  endtask

  task automatic finish_div(input bit w8, input string name);
    @(negedge clk);
    if (w8) start8 = 1'b0; else start32 = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (cur_rdy(w8) !== 1'b0 || cur_res(w8) !== 64'd0)
      begin errors++; $display("FAIL %s release: got ready=%b result=%h, required ready=0 result=0", name, cur_rdy(w8), cur_res(w8)); end
  endtask

  task automatic test_reset;
    rst32 = 1'b0; rst8 = 1'b0;
    sg32 = 0; op1_32 = 0; op2_32 = 0; start32 = 0; annul32 = 0;
    sg8 = 0; op1_8 = 0; op2_8 = 0; start8 = 0; annul8 = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (rdy32 !== 1'b0 || res32 !== 64'd0)
      begin errors++; $display("FAIL reset32: got ready=%b result=%h, required 0/0", rdy32, res32); end
    checks++;
    if (rdy8 !== 1'b0 || res8 !== 16'd0)
      begin errors++; $display("FAIL reset8: got ready=%b result=%h, required 0/0", rdy8, res8); end
    @(negedge clk);
    rst32 = 1'b1; rst8 = 1'b1;
  endtask

  task automatic test_unsigned;
    start_div(0, 0, 32'd100, 32'd7);
    wait_result(0, 33, 0, "u100_7");
    finish_div(0, "u100_7");
    start_div(0, 0, 32'hFFFFFFF9, 32'd2);
    wait_result(0, 33, 0, "uFFF9_2");
    finish_div(0, "uFFF9_2");
  endtask

  task automatic test_signed;
    start_div(0, 1, 32'hFFFFFFF9, 32'd2);
    wait_result(0, 33, 0, "s-7_2");
    finish_div(0, "s-7_2");
    start_div(0, 1, 32'h80000000, 32'hFFFFFFFF);
    wait_result(0, 33, 0, "smin_-1");
    finish_div(0, "smin_-1");
    start_div(0, 1, 32'd7, 32'hFFFFFFFE);
    wait_result(0, 33, 0, "s7_-2");
    finish_div(0, "s7_-2");
  endtask

  task automatic test_div_zero;
    start_div(0, 0, 32'd5, 32'd0);
    wait_result(0, 1, 0, "div0");
    finish_div(0, "div0");
  endtask

  task automatic test_input_change;
    start_div(0, 1, 32'hFFFFF000, 32'd13);
    wait_result(0, 33, 1, "opchange");
    finish_div(0, "opchange");
  endtask

  task automatic test_annul;
    start_div(0, 0, 32'd100, 32'd7);
    repeat (10) @(posedge clk);
    @(negedge clk);
    annul32 = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (rdy32 !== 1'b0 || res32 !== 64'd0)
      begin errors++; $display("FAIL annul: got ready=%b result=%h, required 0/0", rdy32, res32); end
    void'(sb32.pop_back());  // cancelled division produces no result
    start_div(0, 0, 32'd9, 32'd3);
    wait_result(0, 33, 0, "after_annul");
    finish_div(0, "after_annul");
  endtask

  task automatic test_width8;
    start_div(1, 0, 32'd200, 32'd3);
    wait_result(1, 9, 0, "w8_200_3");
    finish_div(1, "w8_200_3");
    start_div(1, 1, 32'h000000F3, 32'd4);
    wait_result(1, 9, 0, "w8_s-13_4");
    finish_div(1, "w8_s-13_4");
  endtask

  task automatic test_reset_midrun;
    start_div(1, 0, 32'd200, 32'd3);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst8 = 1'b0;
    start8 = 1'b0;
    #1;
    checks++;
    if (rdy8 !== 1'b0 || res8 !== 16'd0)
      begin errors++; $display("FAIL rst_midrun: got ready=%b result=%h, required 0/0", rdy8, res8); end
    void'(sb8.pop_back());
    @(negedge clk);
    rst8 = 1'b1;
    start_div(1, 0, 32'd250, 32'd7);
    wait_result(1, 9, 0, "w8_after_rst");
    // Reset in END must clear the held result without a clock edge.
    @(negedge clk);
    rst8 = 1'b0;
    #1;
    checks++;
    if (rdy8 !== 1'b0 || res8 !== 16'd0)
      begin errors++; $display("FAIL rst_async_end: got ready=%b result=%h, required 0/0", rdy8, res8); end
    start8 = 1'b0;
    @(negedge clk);
    rst8 = 1'b1;
    start_div(1, 0, 32'd99, 32'd10);
    wait_result(1, 9, 0, "w8_final");
    finish_div(1, "w8_final");
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_input_change();
    test_annul();
    test_width8();
    test_reset_midrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
